id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RV32I 5-stage core; sits directly upstream of the ALU and drives its src_a, src_b and alu_control.
- Registers decoded operands and control, selects forwarded operands from MEM/WB, detects load-use hazards and inserts bubbles.
- Also produces pc_target_e (PC + immediate) for the branch/jump path.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- stall_e  in  1  hold E register contents (downstream stall)
- flush_e  in  1  squash E (taken branch/jump)
- valid_d  in  1  decode slot holds a real instruction
- pc_d  in  XLEN  decode PC
- rd1_d  in  XLEN  register file read data 1
- rd2_d  in  XLEN  register file read data 2
- imm_ext_d  in  XLEN  sign-extended immediate
- rs1_d  in  REG_ADDR_W  source register 1 index
- rs2_d  in  REG_ADDR_W  source register 2 index
- rd_d  in  REG_ADDR_W  destination register index
- alu_control_d  in  3  ALU op code
- alu_src_d  in  1  1 = immediate as operand B
- reg_write_d  in  1  writes rd
- mem_write_d  in  1  store
- result_src_d  in  2  00 ALU, 01 load, 10 PC+4
- alu_result_m  in  XLEN  MEM-stage ALU result
- rd_m  in  REG_ADDR_W  MEM-stage destination register
- reg_write_m  in  1  MEM-stage write enable
- result_w  in  XLEN  WB-stage result
- rd_w  in  REG_ADDR_W  WB-stage destination register
- reg_write_w  in  1  WB-stage write enable
- src_a_e  out  XLEN  ALU operand A
- src_b_e  out  XLEN  ALU operand B
- alu_control_e  out  3  ALU op code
- write_data_e  out  XLEN  forwarded rs2 value (store data)
- pc_e  out  XLEN  execute-stage PC
- pc_target_e  out  XLEN  pc_e + imm_e
- rd_e  out  REG_ADDR_W  execute-stage destination register
- reg_write_e, mem_write_e, valid_e  out  1 each  execute-stage controls
- result_src_e  out  2  execute-stage result select
- hazard_stall_d  out  1  load-use stall request to fetch/decode
- stall_count  out  32  load-use bubble counter (feature-gated)

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high; all E registers clear to 0, so every registered output is 0 and valid_e=0.
- Update priority per rising edge: rst > flush_e > stall_e > load-use bubble > normal load.
- flush_e: E becomes a bubble: valid, reg_write, mem_write, result_src, rd, alu_control cleared to 0; data registers cleared to 0.
- stall_e without flush_e: all E registers hold. No bubble is inserted.
- Load-use hazard (combinational): hazard_stall_d = valid_e & reg_write_e & (result_src_e==01) & (rd_e!=0) & valid_d & ((rd_e==rs1_d) | (rd_e==rs2_d)).
  - When it is asserted and stall_e=0, the next edge loads a bubble. The upstream stage holds D for that cycle.
- Normal load: all *_d fields captured into E; valid_e <= valid_d. Controls with valid_d=0 are loaded as 0.
- Forwarding (combinational from registered rs1_e/rs2_e):
  - MEM hit = reg_write_m & rd_m!=0 & rd_m==rsX_e, selects alu_result_m.
  - Else WB hit = reg_write_w & rd_w!=0 & rd_w==rsX_e, selects result_w.
  - Else the registered rdX_e is used. MEM has priority over WB. x0 is never forwarded.
- src_a_e = forwarded rs1. write_data_e = forwarded rs2. src_b_e = alu_src_e ? imm_e : forwarded rs2.
- pc_target_e = pc_e + imm_e, modulo 2^XLEN (wraps, no carry out).
- flush_e and hazard together: flush wins, result is a bubble. hazard_stall_d remains a pure function of the current E/D state.
- Reset asserted mid-stall clears E immediately, without waiting for a clock edge.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: stall_count increments by 1 on each edge where a load-use bubble is inserted (hazard_stall_d=1, stall_e=0, flush_e=0). It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: stall_count is tied to 0 and no counter logic is present.

Test Plan:
- Reset: rst=1 asynchronously with clk idle → all outputs 0, valid_e=0, hazard_stall_d=0.
- ADDI x5,x0,7 path: rd1_d=0, imm_ext_d=7, alu_src_d=1, alu_control_d=000, no forwarding hit → next cycle src_a_e=0, src_b_e=7, alu_control_e=000, rd_e=5.
- Forward priority: rs1_e=3, rd_m=3, reg_write_m=1, alu_result_m=0x11; rd_w=3, reg_write_w=1, result_w=0x22 → src_a_e=0x11. Then reg_write_m=0 → src_a_e=0x22. Then rd_m=rd_w=0 with rs1_e=0 → src_a_e=rd1_e.
- Load-use: E holds lw x4 (result_src_e=01, rd_e=4), D has rs2_d=4, valid_d=1 → hazard_stall_d=1; next edge valid_e=0, reg_write_e=0, mem_write_e=0; stall_count goes 0→1 when the macro is defined.
- Flush and stall: flush_e=1 with stall_e=1 → bubble loaded. stall_e=1 alone for 3 cycles → E outputs unchanged.
- Target wrap: pc_e=0xFFFFFFFC, imm_e=8 → pc_target_e=0x00000004.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the RV32I 5-stage core.
// Captures decoded operands and controls, forwards from MEM/WB, detects
// load-use hazards and inserts bubbles, and computes the branch/jump target.
// Optional load-use bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  valid_d,
    input  logic [XLEN-1:0]       pc_d,
    input  logic [XLEN-1:0]       rd1_d,
    input  logic [XLEN-1:0]       rd2_d,
    input  logic [XLEN-1:0]       imm_ext_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic [2:0]            alu_control_d,
    input  logic                  alu_src_d,
    input  logic                  reg_write_d,
    input  logic                  mem_write_d,
    input  logic [1:0]            result_src_d,
    input  logic [XLEN-1:0]       alu_result_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [XLEN-1:0]       result_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic [XLEN-1:0]       src_a_e,
    output logic [XLEN-1:0]       src_b_e,
    output logic [2:0]            alu_control_e,
    output logic [XLEN-1:0]       write_data_e,
    output logic [XLEN-1:0]       pc_e,
    output logic [XLEN-1:0]       pc_target_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  reg_write_e,
    output logic                  mem_write_e,
    output logic                  valid_e,
    output logic [1:0]            result_src_e,
    output logic                  hazard_stall_d,
    output logic [31:0]           stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            alu_control;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_write;
        logic [1:0]            result_src;
    } e_regs_t;

    e_regs_t e_q, e_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use detection: E holds a load whose rd feeds a live instruction in D.
    always_comb begin
        hazard_stall_d = e_q.valid & e_q.reg_write & (e_q.result_src == 2'b01) &
                         (e_q.rd != '0) & valid_d &
                         ((e_q.rd == rs1_d) | (e_q.rd == rs2_d));
    end

    // Next E contents: flush > stall (hold) > load-use bubble > normal load.
    always_comb begin
        e_d = e_q;
        if (flush_e) begin
            e_d = '0;
        end else if (stall_e) begin
            e_d = e_q;
        end else if (hazard_stall_d) begin
            e_d = '0;
        end else begin
            e_d.valid       = valid_d;
            e_d.pc          = pc_d;
            e_d.rd1         = rd1_d;
            e_d.rd2         = rd2_d;
            e_d.imm         = imm_ext_d;
            e_d.rs1         = rs1_d;
            e_d.rs2         = rs2_d;
            e_d.rd          = rd_d;
            e_d.alu_control = alu_control_d;
            e_d.alu_src     = alu_src_d;
            e_d.reg_write   = reg_write_d;
            e_d.mem_write   = mem_write_d;
            e_d.result_src  = result_src_d;
            // An empty decode slot must not carry side-effecting controls into E.
            if (!valid_d) begin
                e_d.rd          = '0;
                e_d.alu_control = '0;
                e_d.reg_write   = 1'b0;
                e_d.mem_write   = 1'b0;
                e_d.result_src  = '0;
            end
        end
    end

    // E register bank with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    // Operand forwarding: MEM result beats WB result; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = e_q.rd1;
        fwd_rs2 = e_q.rd2;
        if (reg_write_m && (rd_m != '0) && (rd_m == e_q.rs1)) begin
            fwd_rs1 = alu_result_m;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == e_q.rs1)) begin
            fwd_rs1 = result_w;
        end
        if (reg_write_m && (rd_m != '0) && (rd_m == e_q.rs2)) begin
            fwd_rs2 = alu_result_m;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == e_q.rs2)) begin
            fwd_rs2 = result_w;
        end
    end

    // Execute-stage outputs driven from E registers and forwarded operands.
    always_comb begin
        src_a_e       = fwd_rs1;
        write_data_e  = fwd_rs2;
        src_b_e       = e_q.alu_src ? e_q.imm : fwd_rs2;
        pc_target_e   = e_q.pc + e_q.imm;
        alu_control_e = e_q.alu_control;
        pc_e          = e_q.pc;
        rd_e          = e_q.rd;
        reg_write_e   = e_q.reg_write;
        mem_write_e   = e_q.mem_write;
        valid_e       = e_q.valid;
        result_src_e  = e_q.result_src;
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of load-use bubbles actually inserted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall_d && !stall_e && !flush_e && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst;
    logic        stall_e, flush_e, valid_d;
    logic [31:0] pc_d, rd1_d, rd2_d, imm_ext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [2:0]  alu_control_d;
    logic        alu_src_d, reg_write_d, mem_write_d;
    logic [1:0]  result_src_d;
    logic [31:0] alu_result_m, result_w;
    logic [4:0]  rd_m, rd_w;
    logic        reg_write_m, reg_write_w;
    logic [31:0] src_a_e, src_b_e, write_data_e, pc_e, pc_target_e;
    logic [2:0]  alu_control_e;
    logic [4:0]  rd_e;
    logic        reg_write_e, mem_write_e, valid_e, hazard_stall_d;
    logic [1:0]  result_src_e;
    logic [31:0] stall_count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt;

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .pc_d(pc_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
        .result_src_d(result_src_d), .alu_result_m(alu_result_m),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .result_w(result_w),
        .rd_w(rd_w), .reg_write_w(reg_write_w), .src_a_e(src_a_e),
        .src_b_e(src_b_e), .alu_control_e(alu_control_e),
        .write_data_e(write_data_e), .pc_e(pc_e), .pc_target_e(pc_target_e),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .valid_e(valid_e), .result_src_e(result_src_e),
        .hazard_stall_d(hazard_stall_d), .stall_count(stall_count)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic [2:0] ctl, input logic asrc, input logic rw,
                         input logic mw, input logic [1:0] rsrc);
        valid_d = v; pc_d = pc; rd1_d = r1; rd2_d = r2; imm_ext_d = imm;
        rs1_d = s1; rs2_d = s2; rd_d = d; alu_control_d = ctl; alu_src_d = asrc;
        reg_write_d = rw; mem_write_d = mw; result_src_d = rsrc;
    endtask

    initial begin
`ifdef ID_EX_PERF_CNT_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        set_d(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        alu_result_m = '0; result_w = '0; rd_m = '0; rd_w = '0;
        reg_write_m = 1'b0; reg_write_w = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(valid_e), 32'd0);
        check("rst_pc", pc_e, 32'd0);
        check("rst_hazard", 32'(hazard_stall_d), 32'd0);
        check("rst_cnt", stall_count, 32'd0);
        rst = 1'b0;

        // ADDI x5, x0, 7
        set_d(1'b1, 32'h100, 32'h0, 32'h55, 32'd7, 5'd0, 5'd0, 5'd5, 3'b000, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        check("addi_src_a", src_a_e, 32'd0);
        check("addi_src_b", src_b_e, 32'd7);
        check("addi_alu", 32'(alu_control_e), 32'd0);
        check("addi_rd", 32'(rd_e), 32'd5);
        check("addi_valid", 32'(valid_e), 32'd1);
        check("addi_target", pc_target_e, 32'h107);
        check("addi_wdata", write_data_e, 32'h55);

        // Forwarding priority on rs1=3
        set_d(1'b1, 32'h104, 32'hAA, 32'h99, 32'd0, 5'd3, 5'd9, 5'd6, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00);
        rd_m = 5'd3; reg_write_m = 1'b1; alu_result_m = 32'h11;
        rd_w = 5'd3; reg_write_w = 1'b1; result_w = 32'h22;
        tick();
        check("fwd_mem", src_a_e, 32'h11);
        check("fwd_src_b_nohit", src_b_e, 32'h99);
        reg_write_m = 1'b0; #1;
        check("fwd_wb", src_a_e, 32'h22);
        reg_write_w = 1'b0; #1;
        check("fwd_none", src_a_e, 32'hAA);
        rd_m = 5'd9; reg_write_m = 1'b1; #1;
        check("fwd_rs2_src_b", src_b_e, 32'h11);
        check("fwd_rs2_wdata", write_data_e, 32'h11);

        // x0 never forwarded
        set_d(1'b1, 32'h108, 32'h33, 32'h0, 32'd0, 5'd0, 5'd0, 5'd6, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
        rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd0; reg_write_w = 1'b1;
        tick();
        check("fwd_x0", src_a_e, 32'h33);
        reg_write_m = 1'b0; reg_write_w = 1'b0;

        // lw x4, 16(x2)
        set_d(1'b1, 32'h10C, 32'h1000, 32'h0, 32'h10, 5'd2, 5'd0, 5'd4, 3'b000, 1'b1, 1'b1, 1'b0, 2'b01);
        tick();
        check("lw_rsrc", 32'(result_src_e), 32'd1);
        check("lw_rd", 32'(rd_e), 32'd4);
        check("lw_nohazard", 32'(hazard_stall_d), 32'd0);
        set_d(1'b0, 32'h200, 32'h7, 32'h8, 32'd0, 5'd1, 5'd4, 5'd7, 3'b000, 1'b0, 1'b1, 1'b1, 2'b00);
        #1;
        check("hazard_invalid_d", 32'(hazard_stall_d), 32'd0);
        valid_d = 1'b1; #1;
        check("hazard_set", 32'(hazard_stall_d), 32'd1);
        tick();
        check("bubble_valid", 32'(valid_e), 32'd0);
        check("bubble_rw", 32'(reg_write_e), 32'd0);
        check("bubble_mw", 32'(mem_write_e), 32'd0);
        check("bubble_rd", 32'(rd_e), 32'd0);
        check("bubble_cnt", stall_count, exp_cnt);
        check("bubble_hazard_clr", 32'(hazard_stall_d), 32'd0);
        tick();
        check("after_bubble_valid", 32'(valid_e), 32'd1);
        check("after_bubble_mw", 32'(mem_write_e), 32'd1);
        check("after_bubble_rd", 32'(rd_e), 32'd7);

        // Stall holds for 3 cycles
        set_d(1'b1, 32'h500, 32'h1, 32'h2, 32'd3, 5'd8, 5'd9, 5'd10, 3'b111, 1'b1, 1'b0, 1'b0, 2'b10);
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc_e, 32'h200);
            check("stall_rd", 32'(rd_e), 32'd7);
            check("stall_valid", 32'(valid_e), 32'd1);
        end

        // Flush with stall -> bubble
        flush_e = 1'b1;
        tick();
        check("flush_stall_valid", 32'(valid_e), 32'd0);
        check("flush_stall_pc", pc_e, 32'd0);
        check("flush_stall_rw", 32'(reg_write_e), 32'd0);
        flush_e = 1'b0; stall_e = 1'b0;

        // Flush with hazard -> bubble, counter unchanged
        set_d(1'b1, 32'h300, 32'h0, 32'h0, 32'd0, 5'd2, 5'd0, 5'd4, 3'b000, 1'b1, 1'b1, 1'b0, 2'b01);
        tick();
        set_d(1'b1, 32'h304, 32'h0, 32'h0, 32'd0, 5'd4, 5'd0, 5'd5, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
        #1;
        check("flush_hazard_req", 32'(hazard_stall_d), 32'd1);
        flush_e = 1'b1;
        tick();
        check("flush_hazard_valid", 32'(valid_e), 32'd0);
        check("flush_hazard_cnt", stall_count, exp_cnt);
        flush_e = 1'b0;

        // Target wrap
        set_d(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'd8, 5'd0, 5'd0, 5'd1, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00);
        tick();
        check("target_wrap", pc_target_e, 32'h4);

        // Invalid decode slot loads no controls
        set_d(1'b0, 32'h400, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0, 5'd9, 3'b011, 1'b0, 1'b1, 1'b1, 2'b01);
        tick();
        check("inv_valid", 32'(valid_e), 32'd0);
        check("inv_rw", 32'(reg_write_e), 32'd0);
        check("inv_mw", 32'(mem_write_e), 32'd0);

        // Async reset while stalled, clock halted
        set_d(1'b1, 32'h600, 32'h0, 32'h0, 32'd4, 5'd0, 5'd0, 5'd3, 3'b001, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        check("pre_rst_pc", pc_e, 32'h600);
        stall_e = 1'b1;
        clk_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid_e), 32'd0);
        check("async_rst_pc", pc_e, 32'd0);
        check("async_rst_src_b", src_b_e, 32'd0);
        check("async_rst_cnt", stall_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
